// File: rtl/freq_pkg.sv
// Shared types and widths for the frequency-counter datapath.
// Downstream sum/period stages take their counter width from CNT_W_DEF.
package freq_pkg;
  localparam int CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;
endpackage

// File: rtl/pulse_period_meter_if.sv
// Result bundle published by pulse_period_meter to the downstream stages.
import freq_pkg::*;

interface pulse_period_meter_if #(
  parameter int CNT_W = CNT_W_DEF
);
  logic [CNT_W-1:0] on_count;
  logic [CNT_W-1:0] off_count;
  logic [CNT_W:0]   sum;
  logic             valid;
  logic             timeout;
  logic             busy;

  modport master (output on_count, off_count, sum, valid, timeout, busy);
  modport slave  (input  on_count, off_count, sum, valid, timeout, busy);
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin plus a registered edge detector.
// Rise and fall share the same latency, so measured phase lengths are exact.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      p_q    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~p_q;
  assign fall_o = ~s_o & p_q;
endmodule

// File: rtl/pulse_period_meter.sv
// Measures high/low phase lengths of each full IN period in CLK cycles and
// flags inputs that stop toggling so stale results are not displayed.
import freq_pkg::*;

module pulse_period_meter #(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 2**24-1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 IN,
  pulse_period_meter_if.master res
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic s, rise, fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (CLK),
    .rst    (reset),
    .d_i    (IN),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] on_q, on_d, off_q, off_d;
  logic [CNT_W:0]   sum_q, sum_d;
  logic             valid_q, valid_d, tmo_q, tmo_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      on_q    <= '0;
      off_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      on_q    <= on_d;
      off_q   <= off_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    on_d    = on_q;
    off_d   = off_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        // A fall seen here ends a partial high phase we never measured.
        hi_d = '0;
        lo_d = '0;
        if (rise) begin
          state_d = HIGH;
          hi_d    = ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          lo_d    = ONE;
        end else if (hi_q == TMO) begin
          state_d = IDLE;
          hi_d    = '0;
          lo_d    = '0;
          on_d    = '0;
          off_d   = '0;
          sum_d   = '0;
          tmo_d   = 1'b1;
        end else if (s) begin
          hi_d = hi_q + ONE;
        end
      end
      LOW: begin
        // Rise closes this period and opens the next one in the same cycle.
        if (rise) begin
          state_d = HIGH;
          on_d    = hi_q;
          off_d   = lo_q;
          sum_d   = {1'b0, hi_q} + {1'b0, lo_q};
          valid_d = 1'b1;
          tmo_d   = 1'b0;
          hi_d    = ONE;
          lo_d    = '0;
        end else if (lo_q == TMO) begin
          state_d = IDLE;
          hi_d    = '0;
          lo_d    = '0;
          on_d    = '0;
          off_d   = '0;
          sum_d   = '0;
          tmo_d   = 1'b1;
        end else if (!s) begin
          lo_d = lo_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res.on_count  = on_q;
  assign res.off_count = off_q;
  assign res.sum       = sum_q;
  assign res.valid     = valid_q;
  assign res.timeout   = tmo_q;
  assign res.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: CNT_W=24, SYNC_STAGES=2, TIMEOUT_CYC=100.
module tb_pulse_period_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pulse_period_meter_if #(.CNT_W(24)) bus ();

  pulse_period_meter #(.CNT_W(24), .SYNC_STAGES(2), .TIMEOUT_CYC(100)) dut (
    .CLK   (clk),
    .reset (rst),
    .IN    (din),
    .res   (bus)
  );

  always #5 clk = ~clk;

  // Capture of every valid pulse; cleared while reset is high.
  int          cyc = 0;
  int          vcount = 0;
  int          overlap = 0;
  int          last_vcyc = 0;
  int          last_gap = 0;
  logic [31:0] cap_on  [32];
  logic [31:0] cap_off [32];
  logic [31:0] cap_sum [32];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      vcount  <= 0;
      overlap <= 0;
    end else if (bus.valid === 1'b1) begin
      if (vcount < 32) begin
        cap_on[vcount]  <= 32'(bus.on_count);
        cap_off[vcount] <= 32'(bus.off_count);
        cap_sum[vcount] <= 32'(bus.sum);
      end
      if (vcount > 0) last_gap <= cyc - last_vcyc;
      last_vcyc <= cyc;
      vcount    <= vcount + 1;
      if (bus.timeout !== 1'b0) overlap <= overlap + 1;
    end
  end

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.on_count !== 24'd0 || bus.off_count !== 24'd0 || bus.sum !== 25'd0) begin
      fails++;
      $display("FAIL reset_counts got %0d/%0d/%0d exp 0/0/0", bus.on_count, bus.off_count, bus.sum);
    end
    tests++;
    if (bus.valid !== 1'b0 || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got v%b t%b b%b exp v0 t1 b0", bus.valid, bus.timeout, bus.busy);
    end
  endtask

  task automatic test_square();
    do_reset();
    drive(0, 5);
    drive(1, 10);
    drive(0, 15);
    tests++;
    if (vcount !== 0 || bus.timeout !== 1'b1 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL sq_first_period got n%0d t%b b%b exp n0 t1 b1", vcount, bus.timeout, bus.busy);
    end
    repeat (3) begin
      drive(1, 10);
      drive(0, 15);
    end
    drive(1, 10);
    tests++;
    if (vcount !== 4) begin
      fails++;
      $display("FAIL sq_count got %0d exp 4", vcount);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (cap_on[i] !== 32'd10 || cap_off[i] !== 32'd15 || cap_sum[i] !== 32'd25) begin
        fails++;
        $display("FAIL sq_val[%0d] got %0d/%0d/%0d exp 10/15/25", i, cap_on[i], cap_off[i], cap_sum[i]);
      end
    end
    tests++;
    if (last_gap !== 25 || bus.timeout !== 1'b0 || overlap !== 0) begin
      fails++;
      $display("FAIL sq_gap got gap%0d t%b ov%0d exp gap25 t0 ov0", last_gap, bus.timeout, overlap);
    end
  endtask

  task automatic test_narrow();
    do_reset();
    drive(0, 3);
    repeat (10) begin
      drive(1, 1);
      drive(0, 1);
    end
    drive(1, 8);
    tests++;
    if (vcount !== 10 || last_gap !== 2) begin
      fails++;
      $display("FAIL narrow_count got n%0d gap%0d exp n10 gap2", vcount, last_gap);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap_on[i] !== 32'd1 || cap_off[i] !== 32'd1 || cap_sum[i] !== 32'd2) begin
        fails++;
        $display("FAIL narrow_val[%0d] got %0d/%0d/%0d exp 1/1/2", i, cap_on[i], cap_off[i], cap_sum[i]);
      end
    end
  endtask

  task automatic test_idle_low();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      drive(0, 1);
      tests++;
      if (bus.valid !== 1'b0 || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_low[%0d] got v%b t%b b%b exp v0 t1 b0", i, bus.valid, bus.timeout, bus.busy);
      end
    end
  endtask

  task automatic test_stuck_high();
    do_reset();
    drive(0, 5);
    repeat (3) begin
      drive(1, 10);
      drive(0, 15);
    end
    // Rise detected 3 cycles in, counter reaches 100 at cycle 102, timeout at 103.
    drive(1, 102);
    tests++;
    if (vcount !== 3 || bus.on_count !== 24'd10 || bus.off_count !== 24'd15 ||
        bus.sum !== 25'd25 || bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL stuck_hold got n%0d %0d/%0d/%0d t%b b%b exp n3 10/15/25 t0 b1",
               vcount, bus.on_count, bus.off_count, bus.sum, bus.timeout, bus.busy);
    end
    drive(1, 1);
    tests++;
    if (bus.on_count !== 24'd0 || bus.off_count !== 24'd0 || bus.sum !== 25'd0 ||
        bus.timeout !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL stuck_timeout got %0d/%0d/%0d t%b b%b v%b exp 0/0/0 t1 b0 v0",
               bus.on_count, bus.off_count, bus.sum, bus.timeout, bus.busy, bus.valid);
    end
    drive(1, 20);
    drive(0, 5);
    drive(1, 7);
    drive(0, 8);
    drive(1, 6);
    tests++;
    if (vcount !== 4 || cap_on[3] !== 32'd7 || cap_off[3] !== 32'd8 || cap_sum[3] !== 32'd15 ||
        bus.timeout !== 1'b0 || overlap !== 0) begin
      fails++;
      $display("FAIL stuck_restart got n%0d %0d/%0d/%0d t%b ov%0d exp n4 7/8/15 t0 ov0",
               vcount, cap_on[3], cap_off[3], cap_sum[3], bus.timeout, overlap);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 5);
    drive(1, 10);
    drive(0, 15);
    drive(1, 20);
    tests++;
    if (vcount !== 1 || bus.on_count !== 24'd10) begin
      fails++;
      $display("FAIL rmid_pre got n%0d on%0d exp n1 on10", vcount, bus.on_count);
    end
    // One reset cycle in the middle of the high phase; IN stays high.
    rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    tests++;
    if (bus.on_count !== 24'd0 || bus.sum !== 25'd0 || bus.timeout !== 1'b1 ||
        bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_reset got on%0d sum%0d t%b b%b v%b exp on0 sum0 t1 b0 v0",
               bus.on_count, bus.sum, bus.timeout, bus.busy, bus.valid);
    end
    drive(1, 20);
    drive(0, 15);
    tests++;
    if (vcount !== 0) begin
      fails++;
      $display("FAIL rmid_novalid got %0d exp 0", vcount);
    end
    drive(1, 6);
    tests++;
    if (vcount !== 1 || cap_on[0] !== 32'd20 || cap_off[0] !== 32'd15 || cap_sum[0] !== 32'd35) begin
      fails++;
      $display("FAIL rmid_after got n%0d %0d/%0d/%0d exp n1 20/15/35", vcount, cap_on[0], cap_off[0], cap_sum[0]);
    end
  endtask

  task automatic test_duty_swap();
    do_reset();
    drive(0, 5);
    drive(1, 20);
    drive(0, 5);
    drive(1, 5);
    drive(0, 20);
    drive(1, 6);
    tests++;
    if (vcount !== 2) begin
      fails++;
      $display("FAIL swap_count got %0d exp 2", vcount);
    end
    tests++;
    if (cap_on[0] !== 32'd20 || cap_off[0] !== 32'd5 || cap_sum[0] !== 32'd25) begin
      fails++;
      $display("FAIL swap_first got %0d/%0d/%0d exp 20/5/25", cap_on[0], cap_off[0], cap_sum[0]);
    end
    tests++;
    if (cap_on[1] !== 32'd5 || cap_off[1] !== 32'd20 || cap_sum[1] !== 32'd25) begin
      fails++;
      $display("FAIL swap_second got %0d/%0d/%0d exp 5/20/25", cap_on[1], cap_off[1], cap_sum[1]);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_narrow();
    test_idle_low();
    test_stuck_high();
    test_reset_mid();
    test_duty_swap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
